epoch_calendar_seq: RTL and testbench

Sequential converter from an unsigned seconds count, relative to 00:00:00 on 1 January of a configurable base year, to calendar date and time-of-day fields. It is the parametrised successor to the fixed 2020–2025 combinational converter and supports any input width and base year with full Gregorian leap rules (/4, /100, /400). It sits between the seconds counter and the display/formatting logic and uses a start/busy/done handshake so that no wide combinational divider is needed.

---
 rtl/cal_pkg.sv | 43 ++++
 rtl/seq_restoring_div.sv | 74 +++++++
 rtl/epoch_calendar_seq.sv | 167 ++++++++++++++++
 tb/tb_epoch_calendar_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cal_pkg
// Description : Calendar constants, FSM state type and base-year helper
//               shared by the epoch-to-calendar converter.
// Revision    : 1.0 - initial release
// ============================================================================
package cal_pkg;

    localparam int SEC_PER_DAY  = 86400;
    localparam int SEC_PER_HOUR = 3600;
    localparam int SEC_PER_MIN  = 60;

    // Non-leap month lengths; element 0 is January.
    localparam logic [11:0][4:0] MONTH_DAYS = {
        5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31,
        5'd30, 5'd31, 5'd30, 5'd31, 5'd28, 5'd31
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV,
        ST_YEAR,
        ST_MONTH,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] m4;
        logic [6:0] m100;
        logic [8:0] m400;
    } yr_mod_t;

    function automatic yr_mod_t base_mods(input int year);
        yr_mod_t mods;
        mods.m4   = 2'(year % 4);
        mods.m100 = 7'(year % 100);
        mods.m400 = 9'(year % 400);
        return mods;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_restoring_div.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_div
// Description : Restoring divider by a constant, one quotient bit per cycle.
//               The first bit is resolved on the start edge itself, so done
//               is high in the cycle after DW edges counting the start edge.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_div #(
    parameter int DW      = 32,
    parameter int DIVISOR = 86400
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DW-1:0]                dividend,
    output logic                         done,
    output logic [DW-1:0]                quotient,
    output logic [$clog2(DIVISOR)-1:0]   remainder
);

    localparam int c_rw = $clog2(DIVISOR);
    localparam int c_tw = c_rw + 1;
    localparam int c_cw = $clog2(DW);

    logic [DW-1:0]   r_q;
    logic [c_rw-1:0] r_rem;
    logic [c_cw-1:0] r_cnt;
    logic            r_run;
    logic            r_done;

    logic [DW-1:0]   w_src;
    logic [c_rw-1:0] w_rem_in;
    logic [c_rw:0]   w_trial;
    logic            w_ge;

    // Dividend bits shift out of the top while quotient bits shift in below.
    assign w_src    = start ? dividend : r_q;
    assign w_rem_in = start ? '0 : r_rem;
    assign w_trial  = {w_rem_in, w_src[DW-1]};
    assign w_ge     = (w_trial >= c_tw'(DIVISOR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start || r_run) begin
                r_q   <= {w_src[DW-2:0], w_ge};
                r_rem <= w_ge ? c_rw'(w_trial - c_tw'(DIVISOR)) : w_trial[c_rw-1:0];
            end
            if (start) begin
                r_cnt <= c_cw'(DW - 1);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_cnt <= r_cnt - c_cw'(1);
                if (r_cnt == c_cw'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done      = r_done;
    assign quotient  = r_q;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/epoch_calendar_seq.sv
`default_nettype none
// ============================================================================
// Module      : epoch_calendar_seq
// Description : Sequential seconds-since-base-year to Gregorian date/time
//               converter with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module epoch_calendar_seq
    import cal_pkg::*;
#(
    parameter int T_W       = 32,
    parameter int BASE_YEAR = 2020,
    parameter int YEAR_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [T_W-1:0]    t,
    output logic              busy,
    output logic              done,
    output logic [4:0]        hh,
    output logic [5:0]        mm,
    output logic [5:0]        ss,
    output logic [4:0]        DD,
    output logic [3:0]        MM,
    output logic [YEAR_W-1:0] YYYY
);

    localparam int      c_days_w   = T_W - 16;
    localparam int      c_ext_w    = (c_days_w > 9) ? c_days_w : 9;
    localparam int      c_sod_w    = $clog2(SEC_PER_DAY);
    localparam yr_mod_t c_base_mod = base_mods(BASE_YEAR);

    state_t r_state, w_state_nxt;

    logic [c_days_w-1:0] r_days;
    logic [c_sod_w-1:0]  r_sod;
    logic [YEAR_W-1:0]   r_year;
    logic [3:0]          r_month;
    logic [1:0]          r_m4;
    logic [6:0]          r_m100;
    logic [8:0]          r_m400;
    logic [4:0]          r_hh, r_dd;
    logic [5:0]          r_mm, r_ss;
    logic [3:0]          r_mo;
    logic [YEAR_W-1:0]   r_yyyy;

    logic                w_div_start, w_div_done;
    logic [T_W-1:0]      w_quo;
    logic [c_sod_w-1:0]  w_rem;
    logic                w_leap, w_year_ge, w_month_ge;
    logic [c_ext_w-1:0]  w_days_ext, w_ylen, w_mlen;
    logic [4:0]          w_hh;
    logic [5:0]          w_mm, w_ss;

    assign w_div_start = (r_state == ST_IDLE) && start;

    seq_restoring_div #(
        .DW      (T_W),
        .DIVISOR (SEC_PER_DAY)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_div_start),
        .dividend  (t),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Leap status tracked by wrapping counters instead of dividing the year.
    assign w_leap     = ((r_m4 == 2'd0) && (r_m100 != 7'd0)) || (r_m400 == 9'd0);
    assign w_days_ext = c_ext_w'(r_days);
    assign w_ylen     = w_leap ? c_ext_w'(366) : c_ext_w'(365);
    assign w_mlen     = c_ext_w'(((r_month == 4'd2) && w_leap) ? 5'd29
                                                               : MONTH_DAYS[r_month - 4'd1]);
    assign w_year_ge  = (w_days_ext >= w_ylen);
    assign w_month_ge = (w_days_ext >= w_mlen);

    assign w_hh = 5'(r_sod / c_sod_w'(SEC_PER_HOUR));
    assign w_mm = 6'((r_sod % c_sod_w'(SEC_PER_HOUR)) / c_sod_w'(SEC_PER_MIN));
    assign w_ss = 6'(r_sod % c_sod_w'(SEC_PER_MIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)       w_state_nxt = ST_DIV;
            ST_DIV:   if (w_div_done)  w_state_nxt = ST_YEAR;
            ST_YEAR:  if (!w_year_ge)  w_state_nxt = ST_MONTH;
            ST_MONTH: if (!w_month_ge) w_state_nxt = ST_DONE;
            ST_DONE:                   w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_days  <= '0;
            r_sod   <= '0;
            r_year  <= '0;
            r_month <= '0;
            r_m4    <= '0;
            r_m100  <= '0;
            r_m400  <= '0;
            r_hh    <= '0;
            r_mm    <= '0;
            r_ss    <= '0;
            r_dd    <= '0;
            r_mo    <= '0;
            r_yyyy  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_year <= YEAR_W'(BASE_YEAR);
                    r_m4   <= c_base_mod.m4;
                    r_m100 <= c_base_mod.m100;
                    r_m400 <= c_base_mod.m400;
                end
                ST_DIV: if (w_div_done) begin
                    r_days <= c_days_w'(w_quo);
                    r_sod  <= w_rem;
                end
                ST_YEAR: begin
                    if (w_year_ge) begin
                        r_days <= c_days_w'(w_days_ext - w_ylen);
                        r_year <= r_year + YEAR_W'(1);
                        r_m4   <= r_m4 + 2'd1;
                        r_m100 <= (r_m100 == 7'd99)  ? 7'd0 : r_m100 + 7'd1;
                        r_m400 <= (r_m400 == 9'd399) ? 9'd0 : r_m400 + 9'd1;
                    end else begin
                        r_month <= 4'd1;
                    end
                end
                ST_MONTH: begin
                    if (w_month_ge) begin
                        r_days  <= c_days_w'(w_days_ext - w_mlen);
                        r_month <= r_month + 4'd1;
                    end else begin
                        r_yyyy <= r_year;
                        r_mo   <= r_month;
                        r_dd   <= 5'(r_days) + 5'd1;
                        r_hh   <= w_hh;
                        r_mm   <= w_mm;
                        r_ss   <= w_ss;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == ST_DIV) || (r_state == ST_YEAR) || (r_state == ST_MONTH);
    assign done = (r_state == ST_DONE);
    assign hh   = r_hh;
    assign mm   = r_mm;
    assign ss   = r_ss;
    assign DD   = r_dd;
    assign MM   = r_mo;
    assign YYYY = r_yyyy;

endmodule
`default_nettype wire

// File: tb/tb_epoch_calendar_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_epoch_calendar_seq
// Description : Directed scoreboard bench for epoch_calendar_seq, with one
//               instance at base 2020 and one at base 1970.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_epoch_calendar_seq;

    typedef struct packed {
        logic [11:0] yyyy;
        logic [3:0]  mo;
        logic [4:0]  dd;
        logic [4:0]  hh;
        logic [5:0]  mi;
        logic [5:0]  ss;
    } cal_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_v [2];
    logic [31:0] t_v     [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic [4:0]  hh_v    [2];
    logic [5:0]  mm_v    [2];
    logic [5:0]  ss_v    [2];
    logic [4:0]  dd_v    [2];
    logic [3:0]  mo_v    [2];
    logic [11:0] yyyy_v  [2];
    cal_t        obs     [2];

    cal_t exp_q0 [$];
    cal_t exp_q1 [$];
    int   n_tests;
    int   n_fail;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    epoch_calendar_seq u_dut0 (
        .clk (clk), .rst_n (rst_n), .start (start_v[0]), .t (t_v[0]),
        .busy (busy_v[0]), .done (done_v[0]),
        .hh (hh_v[0]), .mm (mm_v[0]), .ss (ss_v[0]),
        .DD (dd_v[0]), .MM (mo_v[0]), .YYYY (yyyy_v[0])
    );

    epoch_calendar_seq #(.BASE_YEAR (1970)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .start (start_v[1]), .t (t_v[1]),
        .busy (busy_v[1]), .done (done_v[1]),
        .hh (hh_v[1]), .mm (mm_v[1]), .ss (ss_v[1]),
        .DD (dd_v[1]), .MM (mo_v[1]), .YYYY (yyyy_v[1])
    );

    assign obs[0] = {yyyy_v[0], mo_v[0], dd_v[0], hh_v[0], mm_v[0], ss_v[0]};
    assign obs[1] = {yyyy_v[1], mo_v[1], dd_v[1], hh_v[1], mm_v[1], ss_v[1]};

    function automatic cal_t mk(input int y, input int mo, input int d,
                                input int h, input int mi, input int s);
        cal_t c;
        c.yyyy = 12'(y); c.mo = 4'(mo); c.dd = 5'(d);
        c.hh = 5'(h); c.mi = 6'(mi); c.ss = 6'(s);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    task automatic score(input int k);
        cal_t e;
        n_tests++;
        if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            n_fail++;
            $error("FAIL unexpected_done dut%0d observed %0h expected none", k, obs[k]);
        end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            assert (obs[k] === e) else begin
                n_fail++;
                $error("FAIL result dut%0d observed %0h expected %0h", k, obs[k], e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (done_v[0] === 1'b1) score(0);
        if (done_v[1] === 1'b1) score(1);
    end

    task automatic convert(input int k, input logic [31:0] tv, input cal_t e,
                           input int lat, input bit hammer);
        int acc;
        bit got;
        bit busy_ok;
        @(negedge clk);
        start_v[k] = 1'b1;
        t_v[k]     = tv;
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hammer) start_v[k] = 1'b0;
        got     = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done_v[k] === 1'b1) got = 1'b1;
            else begin
                if (busy_v[k] !== 1'b1) busy_ok = 1'b0;
                if (hammer) t_v[k] = $urandom;
            end
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("latency", 64'(cyc - acc), 64'(lat));
        chk("busy_during", 64'(busy_ok), 64'd1);
        chk("busy_at_done", 64'(busy_v[k]), 64'd0);
        if (hammer) begin
            // start stays high through the DONE cycle; it must not re-launch.
            @(negedge clk);
            start_v[k] = 1'b0;
            busy_ok = 1'b1;
            repeat (40) begin
                @(negedge clk);
                if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0) busy_ok = 1'b0;
            end
            chk("no_relaunch", 64'(busy_ok), 64'd1);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        t_v[0] = '0;       t_v[1] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_fields0", 64'(obs[0]), 64'd0);
        chk("reset_fields1", 64'(obs[1]), 64'd0);
        chk("reset_busy", 64'(busy_v[0]), 64'd0);
        chk("reset_done", 64'(done_v[0]), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        convert(0, 32'd0,          mk(2020,  1,  1,  0,  0,  0),  34, 1'b0);
        convert(0, 32'd5097600,    mk(2020,  2, 29,  0,  0,  0),  35, 1'b0);
        convert(0, 32'd5097599,    mk(2020,  2, 28, 23, 59, 59),  35, 1'b0);
        convert(0, 32'd31622399,   mk(2020, 12, 31, 23, 59, 59),  45, 1'b0);
        convert(0, 32'd31622400,   mk(2021,  1,  1,  0,  0,  0),  35, 1'b0);
        repeat (5) @(negedge clk);
        chk("hold", 64'(obs[0]), 64'(mk(2021, 1, 1, 0, 0, 0)));
        convert(0, 32'd2529705600, mk(2100,  3,  1,  0,  0,  0), 116, 1'b0);
        convert(0, 32'd2529619200, mk(2100,  2, 28,  0,  0,  0), 115, 1'b0);
        convert(1, 32'd946684800,  mk(2000,  1,  1,  0,  0,  0),  64, 1'b0);
        convert(1, 32'd951782400,  mk(2000,  2, 29,  0,  0,  0),  65, 1'b0);
        convert(0, 32'hFFFF_FFFF,  mk(2156,  2,  7,  6, 28, 15), 171, 1'b0);
        convert(0, 32'd3459661,    mk(2020,  2, 10,  1,  1,  1),  35, 1'b1);

        // Reset while the year loop is running.
        @(negedge clk);
        t_v[0] = 32'hFFFF_FFFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (50) @(negedge clk);
        chk("busy_before_abort", 64'(busy_v[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_fields", 64'(obs[0]), 64'd0);
        chk("abort_busy", 64'(busy_v[0]), 64'd0);
        chk("abort_done", 64'(done_v[0]), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        convert(0, 32'd31622400,   mk(2021,  1,  1,  0,  0,  0),  35, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
